// File: rtl/uart_tx_arb.sv
// Packet round-robin arbiter sharing one uart_tx: grant registered one cycle after a request, optional tag byte, then pass-through.
// No buffering; m_ready feeds straight back to the granted requester's s_ready, and the grant holds through source bubbles.
module uart_tx_arb #(
   parameter int NUM_PORTS = 4,
   parameter int MAX_LEN   = 64,
   parameter bit HEADER_EN = 1'b1,
   parameter int CNT_W     = $clog2(MAX_LEN + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [8*NUM_PORTS-1:0] s_data,
   input  logic [NUM_PORTS-1:0]   s_valid,
   input  logic [NUM_PORTS-1:0]   s_last,
   output logic [NUM_PORTS-1:0]   s_ready,
   output logic [7:0]             m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [NUM_PORTS-1:0]   grant,
   output logic                   busy
);

   typedef enum logic [1:0] {IDLE, HEADER, DATA} state_t;

   state_t               state, state_n;
   logic [3:0]           idx, idx_n, ptr, ptr_n;
   logic [3:0]           pick_idx, nxt_ptr;
   logic                 pick_vld;
   logic [4:0]           cand;
   logic [CNT_W-1:0]     cnt, cnt_n, cnt_inc;
   logic [NUM_PORTS-1:0] grant_n;
   logic [7:0]           data_ext [16];
   logic [15:0]          valid_ext, last_ext;

   // Widen the requester buses to 16 lanes so a 4-bit index works for any NUM_PORTS.
   for (genvar g = 0; g < 16; g++) begin : g_ext
      if (g < NUM_PORTS) begin : g_on
         assign data_ext[g]  = s_data[8*g +: 8];
         assign valid_ext[g] = s_valid[g];
         assign last_ext[g]  = s_last[g];
      end else begin : g_off
         assign data_ext[g]  = 8'h00;
         assign valid_ext[g] = 1'b0;
         assign last_ext[g]  = 1'b0;
      end
   end

   // First requester at or after ptr, wrapping modulo NUM_PORTS.
   always_comb begin
      pick_vld = 1'b0;
      pick_idx = 4'd0;
      cand     = 5'd0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         cand = 5'(ptr) + 5'(i);
         if (cand >= 5'(NUM_PORTS)) cand = cand - 5'(NUM_PORTS);
         if (!pick_vld && valid_ext[cand[3:0]]) begin
            pick_vld = 1'b1;
            pick_idx = cand[3:0];
         end
      end
   end

   assign nxt_ptr = (idx == 4'(NUM_PORTS - 1)) ? 4'd0 : idx + 4'd1;

   always_comb begin
      state_n = state;
      idx_n   = idx;
      ptr_n   = ptr;
      cnt_n   = cnt;
      grant_n = grant;
      m_valid = 1'b0;
      m_data  = 8'h00;
      s_ready = '0;
      cnt_inc = cnt + 1'b1;
      case (state)
         IDLE: begin
            if (pick_vld) begin
               idx_n   = pick_idx;
               grant_n = NUM_PORTS'(1'b1) << pick_idx;
               state_n = HEADER_EN ? HEADER : DATA;
            end
         end
         HEADER: begin
            m_valid = 1'b1;
            m_data  = {4'hA, idx};
            if (m_ready) state_n = DATA;
         end
         DATA: begin
            m_data  = data_ext[idx];
            m_valid = valid_ext[idx];
            s_ready = NUM_PORTS'(m_ready) << idx;
            if (valid_ext[idx] && m_ready) begin
               cnt_n = cnt_inc;
               // A length-capped packet releases exactly like a finished one; its tail re-arbitrates.
               if (last_ext[idx] || cnt_inc == CNT_W'(MAX_LEN)) begin
                  state_n = IDLE;
                  ptr_n   = nxt_ptr;
                  cnt_n   = '0;
                  grant_n = '0;
               end
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         idx   <= 4'd0;
         ptr   <= 4'd0;
         cnt   <= '0;
         grant <= '0;
      end else begin
         state <= state_n;
         idx   <= idx_n;
         ptr   <= ptr_n;
         cnt   <= cnt_n;
         grant <= grant_n;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-based requesters, packet-level reference model checked every cycle, directed then random traffic.
module tb_uart_tx_arb;
   localparam int NP = 4;
   localparam int ML = 4;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic [8*NP-1:0] s_data = '0;
   logic [NP-1:0] s_valid = '0;
   logic [NP-1:0] s_last = '0;
   logic [NP-1:0] s_ready;
   logic [7:0]    m_data;
   logic          m_valid;
   logic          m_ready = 1'b0;
   logic [NP-1:0] grant;
   logic          busy;

   uart_tx_arb #(.NUM_PORTS(NP), .MAX_LEN(ML), .HEADER_EN(1'b1)) dut (
      .clk(clk), .reset(reset),
      .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
      .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
      .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Requester side: bytes waiting to be accepted, and everything ever offered per port.
   logic [8:0] src_q    [NP][$];
   logic [8:0] sent_log [NP][$];
   logic [NP-1:0] hold = '0;
   bit   rnd_bub = 1'b0;
   int   mr_mode = 0;          // 0 always ready, 1 random, 2 stalled
   bit   chk_on = 1'b0;

   // Written only by the compare process.
   logic [NP-1:0] took = '0;
   logic [7:0]    line_q [$];
   int            rd_idx [NP];
   int            mdl_owner = -1;
   bit            mdl_hdr = 1'b0;
   int            mdl_ptr = 0;
   int            mdl_n = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Reference model: a packet-level view of who owns the line and which byte is owed next.
   int       scan_p;
   bit       found;
   logic [8:0] ent;
   always @(negedge clk) begin
      if (chk_on) begin
         if (mdl_owner < 0) begin
            chk("busy_idle", busy, 0);
            chk("grant_idle", grant, 0);
            chk("mvalid_idle", m_valid, 0);
            chk("sready_idle", s_ready, 0);
         end else begin
            chk("grant_owner", grant, 4'b0001 << mdl_owner);
            chk("busy_owner", busy, 1);
            if (mdl_hdr) begin
               chk("hdr_valid", m_valid, 1);
               chk("hdr_byte", m_data, 8'hA0 + mdl_owner);
               chk("hdr_sready", s_ready, 0);
            end else begin
               chk("data_valid", m_valid, s_valid[mdl_owner]);
               chk("data_sready", s_ready, m_ready ? (4'b0001 << mdl_owner) : 4'b0000);
               if (s_valid[mdl_owner]) begin
                  chk("data_avail", rd_idx[mdl_owner] < sent_log[mdl_owner].size(), 1);
                  if (rd_idx[mdl_owner] < sent_log[mdl_owner].size()) begin
                     ent = sent_log[mdl_owner][rd_idx[mdl_owner]];
                     chk("data_byte", m_data, ent[7:0]);
                  end
               end
            end
         end
      end
      for (int p = 0; p < NP; p++) took[p] = !reset && s_valid[p] && s_ready[p];
      if (!reset && m_valid && m_ready) line_q.push_back(m_data);

      if (reset) begin
         mdl_owner = -1;
         mdl_hdr   = 1'b0;
         mdl_ptr   = 0;
         mdl_n     = 0;
         for (int p = 0; p < NP; p++) rd_idx[p] = sent_log[p].size();
      end else if (mdl_owner < 0) begin
         found = 1'b0;
         for (int k = 0; k < NP; k++) begin
            scan_p = (mdl_ptr + k) % NP;
            if (!found && s_valid[scan_p]) begin
               found     = 1'b1;
               mdl_owner = scan_p;
               mdl_hdr   = 1'b1;
               mdl_n     = 0;
            end
         end
      end else if (mdl_hdr) begin
         if (m_ready) mdl_hdr = 1'b0;
      end else if (s_valid[mdl_owner] && m_ready) begin
         ent = (rd_idx[mdl_owner] < sent_log[mdl_owner].size()) ? sent_log[mdl_owner][rd_idx[mdl_owner]] : 9'h100;
         rd_idx[mdl_owner]++;
         mdl_n++;
         if (ent[8] || mdl_n == ML) begin
            mdl_ptr   = (mdl_owner + 1) % NP;
            mdl_owner = -1;
         end
      end
   end

   // One clock: drive requester/uart inputs just after the edge, return two time units later.
   task automatic cycle();
      logic [8:0] e;
      @(posedge clk);
      #1;
      for (int p = 0; p < NP; p++) begin
         if (took[p] && src_q[p].size() > 0) e = src_q[p].pop_front();
         if (src_q[p].size() > 0) begin
            e = src_q[p][0];
            s_valid[p] = !reset && !hold[p] && !(rnd_bub && $urandom_range(0, 3) == 0);
            s_data[8*p +: 8] = e[7:0];
            s_last[p] = e[8];
         end else begin
            s_valid[p] = 1'b0;
            s_data[8*p +: 8] = 8'h00;
            s_last[p] = 1'b0;
         end
      end
      m_ready = (mr_mode == 0) ? 1'b1 : (mr_mode == 1) ? ($urandom_range(0, 9) < 7) : 1'b0;
      #1;
   endtask

   task automatic push_pkt(input int p, input logic [7:0] d[$]);
      for (int i = 0; i < d.size(); i++) begin
         src_q[p].push_back({(i == d.size() - 1), d[i]});
         sent_log[p].push_back({(i == d.size() - 1), d[i]});
      end
   endtask

   task automatic wait_idle(input int budget, input logic [3:0] exp_gnt);
      int n = 0;
      bit done = 1'b0;
      while (!done && n < budget) begin
         cycle();
         n++;
         if (exp_gnt != 0 && grant != 0) chk("grant_onehot", grant, exp_gnt);
         done = !busy && src_q[0].size() == 0 && src_q[1].size() == 0
                && src_q[2].size() == 0 && src_q[3].size() == 0;
      end
      chk("drain_timeout", done, 1);
   endtask

   task automatic wait_q(input int p, input int lvl, input int budget);
      int n = 0;
      while (src_q[p].size() > lvl && n < budget) begin
         cycle();
         n++;
      end
      chk("progress_timeout", src_q[p].size() <= lvl, 1);
   endtask

   task automatic cmp_stream(input string nm, input int base, input logic [7:0] exp[$]);
      chk({nm, "_len"}, line_q.size() - base, exp.size());
      for (int i = 0; i < exp.size(); i++)
         if (base + i < line_q.size()) chk(nm, line_q[base + i], exp[i]);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      cycle();
      reset = 1'b0;
   endtask

   logic [7:0] pkt [$];
   logic [7:0] exp_s [$];
   int base;

   initial begin
      cycle();
      chk_on = 1'b1;
      cycle();
      cycle();
      reset = 1'b0;
      chk("rst_grant", grant, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mvalid", m_valid, 0);
      chk("rst_sready", s_ready, 0);

      // Single port with header.
      base = line_q.size();
      pkt = '{8'h11, 8'h22, 8'h33};
      push_pkt(2, pkt);
      wait_idle(100, 4'b0100);
      exp_s = '{8'hA2, 8'h11, 8'h22, 8'h33};
      cmp_stream("single", base, exp_s);

      // All four contend from reset; port 0 has a second packet queued.
      do_reset();
      base = line_q.size();
      pkt = '{8'h01, 8'h02}; push_pkt(0, pkt);
      pkt = '{8'h03, 8'h04}; push_pkt(0, pkt);
      pkt = '{8'h11, 8'h12}; push_pkt(1, pkt);
      pkt = '{8'h21, 8'h22}; push_pkt(2, pkt);
      pkt = '{8'h31, 8'h32}; push_pkt(3, pkt);
      wait_idle(200, 4'b0000);
      exp_s = '{8'hA0, 8'h01, 8'h02, 8'hA1, 8'h11, 8'h12, 8'hA2, 8'h21, 8'h22,
                8'hA3, 8'h31, 8'h32, 8'hA0, 8'h03, 8'h04};
      cmp_stream("contend", base, exp_s);

      // Pointer after port 1 puts port 3 ahead of port 0.
      base = line_q.size();
      pkt = '{8'h41}; push_pkt(1, pkt);
      wait_idle(100, 4'b0010);
      pkt = '{8'h50}; push_pkt(0, pkt);
      pkt = '{8'h53}; push_pkt(3, pkt);
      wait_idle(100, 4'b0000);
      exp_s = '{8'hA1, 8'h41, 8'hA3, 8'h53, 8'hA0, 8'h50};
      cmp_stream("rr_ptr", base, exp_s);

      // Six bytes with a four-byte cap: split into two tagged grants.
      base = line_q.size();
      pkt = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66};
      push_pkt(0, pkt);
      wait_idle(100, 4'b0001);
      exp_s = '{8'hA0, 8'h61, 8'h62, 8'h63, 8'h64, 8'hA0, 8'h65, 8'h66};
      cmp_stream("maxlen", base, exp_s);

      // Header stalled 50 cycles, then a 10-cycle source bubble mid-packet.
      base = line_q.size();
      mr_mode = 2;
      pkt = '{8'h71, 8'h72, 8'h73, 8'h74};
      push_pkt(1, pkt);
      repeat (50) cycle();
      chk("stall_mvalid", m_valid, 1);
      chk("stall_mdata", m_data, 8'hA1);
      mr_mode = 0;
      wait_q(1, 3, 100);
      hold[1] = 1'b1;
      repeat (10) cycle();
      chk("bubble_mvalid", m_valid, 0);
      chk("bubble_grant", grant, 4'b0010);
      hold[1] = 1'b0;
      wait_idle(100, 4'b0010);
      exp_s = '{8'hA1, 8'h71, 8'h72, 8'h73, 8'h74};
      cmp_stream("backpr", base, exp_s);

      // Reset after the second of five bytes; the next arbitration restarts at port 0.
      pkt = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85};
      push_pkt(2, pkt);
      wait_q(2, 3, 100);
      reset = 1'b1;
      cycle();
      reset = 1'b0;
      for (int p = 0; p < NP; p++) src_q[p].delete();
      chk("mid_rst_grant", grant, 0);
      chk("mid_rst_mvalid", m_valid, 0);
      chk("mid_rst_sready", s_ready, 0);
      chk("mid_rst_busy", busy, 0);
      base = line_q.size();
      pkt = '{8'h5A}; push_pkt(0, pkt);
      pkt = '{8'h6B}; push_pkt(3, pkt);
      wait_idle(100, 4'b0000);
      exp_s = '{8'hA0, 8'h5A, 8'hA3, 8'h6B};
      cmp_stream("post_rst", base, exp_s);

      // Random traffic: random lengths (some over the cap), bubbles and uart backpressure.
      mr_mode = 1;
      rnd_bub = 1'b1;
      for (int n = 0; n < 40; n++) begin
         pkt.delete();
         for (int b = $urandom_range(1, 7); b > 0; b--) pkt.push_back(8'($urandom));
         push_pkt($urandom_range(0, NP - 1), pkt);
         repeat ($urandom_range(0, 6)) cycle();
      end
      wait_idle(5000, 4'b0000);
      for (int p = 0; p < NP; p++) chk("all_delivered", rd_idx[p], sent_log[p].size());

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
Packet-level round-robin arbiter that shares one uart_tx instance among NUM_PORTS byte-stream requesters.
- Each requester presents bytes with valid/ready/last. The arbiter grants one port and holds the grant until that port's last byte is accepted or MAX_LEN bytes have been forwarded.
- It can prefix each packet with a one-byte source tag.
- Its master side connects directly to the uart_tx data/valid/ready inputs.

Parameters:
NUM_PORTS, 4, number of requesters (1..16)
MAX_LEN, 64, maximum data bytes per grant before forced release (>=1)
HEADER_EN, 1, 1 = emit tag byte {4'hA, port index[3:0]} before each packet's data
CNT_W, $clog2(MAX_LEN+1), width of the byte counter (derived, do not override)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
s_data  in  8*NUM_PORTS  requester bytes; port i occupies bits [8i+7:8i]
s_valid  in  NUM_PORTS  requester byte valid
s_last  in  NUM_PORTS  marks the final byte of the requester's packet
s_ready  out  NUM_PORTS  requester byte accepted when s_valid[i] & s_ready[i]
m_data  out  8  byte to uart_tx
m_valid  out  1  byte valid to uart_tx
m_ready  in  1  uart_tx ready
grant  out  NUM_PORTS  one-hot current owner, 0 when idle
busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high; it is sampled on the rising edge of clk.
- Reset values: state=IDLE, grant=0, ptr=0, cnt=0, busy=0, m_valid=0, s_ready=0.
- Reset mid-operation: in-flight packet abandoned; return to IDLE next edge. No partial header or data continues after reset.
- States:
  - IDLE: m_valid=0, s_ready=0. If any s_valid, pick first asserted index scanning ptr, ptr+1, ... mod NUM_PORTS. Register grant/idx. Next state is HEADER if HEADER_EN, else DATA. Arbitration uses s_valid sampled this cycle only.
  - HEADER: m_valid=1, m_data={4'hA, idx}, s_ready=0. On m_valid&m_ready go to DATA. m_valid and m_data stay stable until the handshake.
  - DATA: m_data=s_data[idx], m_valid=s_valid[idx], s_ready[idx]=m_ready, other s_ready=0. Each handshake increments cnt.
    - If the handshake byte has s_last[idx]: go to IDLE, ptr=(idx+1) mod NUM_PORTS, cnt=0, grant=0.
    - Else if the incremented cnt==MAX_LEN: forced release with the same updates as above; the remainder of the packet re-arbitrates as a new packet.
- Latency:
  - Request seen in IDLE -> grant asserted next cycle.
  - With HEADER_EN, the first data byte can be accepted no earlier than the cycle after the header handshake.
  - Minimum idle gap between grants is 1 cycle (the IDLE state).
- Fairness: each contending port waits at most NUM_PORTS-1 grants.
- Datapath: no buffering; combinational pass-through from the granted port to m_* and from m_ready to s_ready.
- Bubbles: a granted port may deassert s_valid mid-packet; the grant is held (no timeout) and m_valid follows it.
- NUM_PORTS=1: always grants port 0; ptr stays 0.

Test Plan:
- Single port, HEADER_EN=1: port 2 sends 3 bytes {11,22,33}, last on 33 -> UART line carries A2,11,22,33; grant=4'b0100 during the packet; busy drops the cycle after 33 is accepted.
- Contention: all 4 ports valid with 2-byte packets from reset -> serviced in order 0,1,2,3, then 0 again. Headers A0..A3 precede each packet; no interleaving of bytes between ports.
- Round-robin pointer: port 1 finishes, then ports 0 and 3 request simultaneously -> port 3 granted first, then port 0.
- MAX_LEN=4: port 0 sends 6 bytes with last on the 6th -> A0 + 4 bytes, forced release, then A0 + remaining 2 bytes. cnt resets between the two grants.
- Backpressure and bubbles: hold m_ready low 50 cycles during HEADER; port drops s_valid 10 cycles mid-packet -> m_data/m_valid stable throughout, no byte lost or duplicated, received stream matches sent.
- Reset mid-packet: assert reset after the 2nd of 5 bytes -> next cycle grant=0, m_valid=0, s_ready=0. A fresh request afterwards is granted starting from port 0 and emits its header.
